// File: rtl/seq_stim_driver.sv
// seq_stim_driver
// Clock-aligned arithmetic sample source. It emits init, init+step,
// init+2*step, ... on a valid/ready stream and pulses done once the
// requested number of samples has been accepted.
//
// Every output is a flop. No combinational path runs from any input to
// any output.
//
// Optional build macro: SEQ_STIM_DRIVER_PARITY_EN
//   When defined, this adds the dout_par output, the XOR reduction of dout,
//   registered alongside dout.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; init_val/step/count are sampled here only
// S_RUN  | presenting samples; advancing on each accepted transfer
// S_DONE | single completion cycle with done high, then back to S_IDLE

module seq_stim_driver #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    init_val,
  input  logic [DW-1:0]    step,
  input  logic [CNT_W-1:0] count,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
`ifdef SEQ_STIM_DRIVER_PARITY_EN
  ,
  output logic             dout_par
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [DW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer;

`ifdef SEQ_STIM_DRIVER_PARITY_EN
  logic             par_q;
`endif

  assign xfer = valid_q & dout_ready;

  // Next-state and next-output logic; every register holds unless a branch moves it.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    step_d  = step_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            step_d  = step;
            rem_d   = count;
            dout_d  = init_val;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            // An empty sequence still reports completion so the requester
            // always sees exactly one done per accepted start.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (xfer) begin
          if (rem_q > REM_ONE) begin
            dout_d = dout_q + step_q;
            rem_d  = rem_q - REM_ONE;
          end else begin
            // dout keeps the last sample; only valid/busy drop.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            rem_d   = '0;
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        rem_d   = '0;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_STIM_DRIVER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_STIM_DRIVER_PARITY_EN
      par_q   <= ^dout_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SEQ_STIM_DRIVER_PARITY_EN
  assign dout_par   = par_q;
`endif

endmodule

// File: doc/seq_stim_driver.md
Name: seq_stim_driver

Overview:
- Source end of the clocked `din` data path. Generates an arithmetic sample sequence (init, init+step, init+2*step, ...) and presents it on a valid/ready stream.
- Feeds registered samplers/DUT inputs from a clean, clock-aligned source, instead of delay-based testbench stimulus.
- All outputs come straight from flops, updated with non-blocking assignments only.

Parameters:
- DW, 8, data width of `init_val`, `step` and `dout`.
- CNT_W, 8, width of `count` and of the internal remaining-sample counter.

Ports:
- clk  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- init_val  in  DW  first sample value.
- step  in  DW  increment between samples (unsigned, modulo 2^DW).
- count  in  CNT_W  number of samples to emit; 0 is legal.
- dout  out  DW  current sample.
- dout_valid  out  1  `dout` holds a sample awaiting transfer.
- dout_ready  in  1  sink accepts `dout` this cycle.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; dout=0, dout_valid=0, busy=0, done=0; remaining=0. Reset has priority over every other input.
- States:
  - IDLE: waiting for `start`.
  - RUN: emitting samples.
  - DONE: one-cycle completion state, then back to IDLE.
- IDLE, start=1 and count!=0:
  - Latch step and count into internal registers.
  - dout<=init_val, dout_valid<=1, busy<=1, remaining<=count.
  - Next state RUN.
- IDLE, start=1 and count==0:
  - Next state DONE; dout_valid and busy stay 0.
- IDLE, start=0: hold all outputs; done=0.
- Transfer definition: a transfer occurs at an edge where dout_valid=1 and dout_ready=1.
- RUN, transfer with remaining>1:
  - dout<=dout+step, truncated to DW bits (wraps, no saturation, no overflow flag).
  - remaining<=remaining-1; dout_valid stays 1.
- RUN, transfer with remaining==1:
  - dout_valid<=0, busy<=0, next state DONE.
  - dout keeps the last value.
- RUN, no transfer: dout, dout_valid and remaining hold. `dout` must not change while valid and not accepted.
- DONE: done=1 for exactly this one cycle; next state IDLE, where done<=0.
- Timing:
  - `start` sampled at edge N puts the first sample on `dout` after edge N.
  - The first transfer is possible at edge N+1.
  - With dout_ready held high, `count` samples transfer on `count` consecutive edges.
  - done=1 in the cycle after the last transfer edge.
- Ignored inputs:
  - `start` is ignored outside IDLE, including in DONE; no queueing.
  - init_val, step and count are sampled only at the accepted start; changes during RUN have no effect.
- `dout_ready` is don't-care when dout_valid=0.
- No combinational path from any input to any output.
- Reset mid-RUN: the sequence aborts and outputs take reset values at that edge. No `done` pulse; no partial sample is retained.
- Maximum sequence length: 2^CNT_W - 1 samples.

Optional Feature:
- Macro: SEQ_STIM_DRIVER_PARITY_EN.
- Defined:
  - Adds output port `dout_par` (1 bit), the even parity (XOR reduction) of the value `dout` will hold.
  - Registered in the same always_ff as `dout`, so it changes on exactly the same edges; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. init_val=3, step=2, count=4, dout_ready=1 -> dout 3,5,7,9 transfer on 4 consecutive edges; done=1 for one cycle after the edge that transfers 9; busy high exactly during RUN.
2. Same as 1, dout_ready=0 for 2 cycles while dout=5 -> 5 held stable with dout_valid=1; no skipped or repeated value; sequence still 3,5,7,9.
3. init_val=250, step=4, count=3 -> dout 250,254,2 (mod-256 wrap); done after 2.
4. count=0 with start -> dout_valid and busy stay 0; done pulses for one cycle, one cycle after start.
5. init_val=3, step=2, count=4; rst=1 after 2 transfers (3,5) -> at that edge dout=0, dout_valid=0, busy=0, no done. Then a new start with init_val=10, step=1, count=2 -> 10,11.
6. start pulsed during RUN with different init_val -> ignored, original sequence completes unchanged. With SEQ_STIM_DRIVER_PARITY_EN defined, dout_par=0,0,1,0 for 3,5,7,9.
